// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 2;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries for decode.
// Head entry is read straight from registered storage; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output logic             head_valid,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    // Popping an empty queue is a no-op.
    assign pop_ok     = pop && (count != '0);
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is only DEPTH flops deep, so it is cleared on reset to give a defined head (0) after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one imem read per accepted PC, tags the response with its PC,
// queues it for decode, and drops stale responses after a redirect.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_ready,
    input  logic              redirect_valid,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    fetch_state_t     state;
    logic [ADDR_W-1:0] tag;
    logic [CNT_W-1:0]  count;
    logic              req_fire;
    logic              push;
    logic              head_valid;
    entry_t            push_data;
    entry_t            head;

    // Request depends only on registered state, the PC and redirect, never on decode or memory responses.
    assign imem_req_valid = !rst && (state == FETCH) && (count < CNT_W'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_ready       = !rst && (req_fire || redirect_valid);

    // A response coinciding with a redirect belongs to the old path and is dropped.
    assign push           = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign push_data      = '{pc: tag, instr: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            tag   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (req_fire) begin
                        tag   <= pc;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= FETCH;
                    end else if (redirect_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_data),
        .pop        (id_ready),
        .head_valid (head_valid),
        .head       (head),
        .count      (count)
    );

    assign if_valid = head_valid;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: bench-side PC register and imem model,
// directed scenarios push expected entries, a monitor checks every decode pop.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] pc = '0;
    logic              pc_ready;
    logic              redirect_valid = 1'b0;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b0;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] imem_rsp_data = '0;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              id_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_ready       (pc_ready),
        .redirect_valid (redirect_valid),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 1;

    logic              d_rst       = 1'b1;
    logic              d_id_ready  = 1'b0;
    logic              d_req_ready = 1'b1;
    logic              d_redirect  = 1'b0;
    logic [ADDR_W-1:0] d_target    = '0;
    logic [ADDR_W-1:0] pc_model    = '0;
    logic              fired       = 1'b0;
    logic [ADDR_W-1:0] fire_addr   = '0;

    function automatic logic [DATA_W-1:0] imem_word(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = imem_word(a);
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive inputs at the falling edge, then record what the
    // coming rising edge will do (request handshake, PC register update).
    task automatic tick();
        pend_t p;
        @(negedge clk);
        rst            = d_rst;
        id_ready       = d_id_ready;
        imem_req_ready = d_req_ready;
        redirect_valid = d_redirect;
        pc             = pc_model;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (d_rst) begin
            pend_q.delete();
        end else if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            p              = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = imem_word(p.addr);
        end
        #1;
        fired     = !d_rst && imem_req_valid && imem_req_ready;
        fire_addr = imem_req_addr;
        if (fired) begin
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend_q.push_back(p);
        end
        if (d_rst) begin
            pc_model = '0;
        end else if (pc_ready) begin
            pc_model = d_redirect ? d_target : pc_model + 1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        d_rst       = 1'b1;
        d_redirect  = 1'b0;
        d_id_ready  = 1'b0;
        d_req_ready = 1'b1;
        exp_q.delete();
        tick();
        tick();
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_if_instr", 64'(if_instr), 64'd0);
        check("rst_if_pc", 64'(if_pc), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_pc_ready", 64'(pc_ready), 64'd0);
        d_rst = 1'b0;
    endtask

    task automatic run_until_drained(input string name, input int budget);
        int n;
        n          = 0;
        d_id_ready = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            #2;
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        d_id_ready = 1'b0;
    endtask

    // Monitor: every decode pop is compared against the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (if_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_pop: got pc 0x%0h, expected no entry", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_if_pc", 64'(if_pc), 64'(e.pc));
                    check("pop_if_instr", 64'(if_instr), 64'(e.instr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nf;

        // Streaming with 1-cycle memory: one instruction every two cycles.
        do_reset();
        lat = 1;
        for (int i = 0; i < 4; i++) push_exp(ADDR_W'(i));
        d_id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_pc_ready", 64'(pc_ready), 64'(i % 2 == 0));
        end
        run_until_drained("t1", 20);

        // Decode stalled: queue fills to DEPTH, requests stop, head holds.
        do_reset();
        lat = 1;
        nf  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fired) begin
                check("t2_req_addr", 64'(fire_addr), 64'(nf));
                nf++;
            end
        end
        check("t2_num_req", 64'(nf), 64'(DEPTH));
        check("t2_req_valid_low", 64'(imem_req_valid), 64'd0);
        check("t2_if_valid", 64'(if_valid), 64'd1);
        check("t2_head_pc", 64'(if_pc), 64'd0);
        check("t2_head_instr", 64'(if_instr), 64'h1000_0000);
        push_exp(32'd0);
        push_exp(32'd1);
        push_exp(32'd2);
        run_until_drained("t2", 20);

        // Memory back-pressure: request held stable, PC not advanced.
        do_reset();
        lat = 1;
        push_exp(32'd0);
        push_exp(32'd1);
        d_id_ready  = 1'b1;
        d_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_req_valid_held", 64'(imem_req_valid), 64'd1);
            check("t3_req_addr_stable", 64'(imem_req_addr), 64'd0);
            check("t3_pc_ready_low", 64'(pc_ready), 64'd0);
        end
        d_req_ready = 1'b1;
        tick();
        check("t3_pc_ready_accept", 64'(pc_ready), 64'd1);
        check("t3_fired", 64'(fired), 64'd1);
        run_until_drained("t3", 20);

        // Redirect while a 4-cycle read is outstanding: flush and drain.
        do_reset();
        lat = 4;
        for (int i = 0; i < 6; i++) tick();
        check("t4_pre_if_valid", 64'(if_valid), 64'd1);
        d_redirect = 1'b1;
        d_target   = 32'h40;
        tick();
        check("t4_redir_pc_ready", 64'(pc_ready), 64'd1);
        check("t4_redir_req_valid", 64'(imem_req_valid), 64'd0);
        d_redirect = 1'b0;
        push_exp(32'h40);
        d_id_ready = 1'b1;
        tick();
        check("t4_flushed", 64'(if_valid), 64'd0);
        check("t4_drain_no_req", 64'(imem_req_valid), 64'd0);
        run_until_drained("t4", 30);

        // Redirect coinciding with the response: word dropped, refetch at target.
        do_reset();
        lat = 1;
        tick();
        check("t5_first_fire", 64'(fired), 64'd1);
        d_redirect = 1'b1;
        d_target   = 32'h80;
        tick();
        check("t5_redir_pc_ready", 64'(pc_ready), 64'd1);
        d_redirect = 1'b0;
        tick();
        check("t5_not_enqueued", 64'(if_valid), 64'd0);
        check("t5_req_valid", 64'(imem_req_valid), 64'd1);
        check("t5_req_addr", 64'(imem_req_addr), 64'h80);
        push_exp(32'h80);
        run_until_drained("t5", 20);

        // Reset with a full queue: everything clears and fetch restarts at 0.
        do_reset();
        lat = 1;
        for (int i = 0; i < 5; i++) tick();
        check("t6_full_if_valid", 64'(if_valid), 64'd1);
        check("t6_full_no_req", 64'(imem_req_valid), 64'd0);
        d_rst = 1'b1;
        tick();
        check("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("t6_rst_pc_ready", 64'(pc_ready), 64'd0);
        d_rst = 1'b0;
        tick();
        check("t6_post_if_valid", 64'(if_valid), 64'd0);
        check("t6_post_if_pc", 64'(if_pc), 64'd0);
        check("t6_post_if_instr", 64'(if_instr), 64'd0);
        check("t6_post_req_valid", 64'(imem_req_valid), 64'd1);
        check("t6_post_req_addr", 64'(imem_req_addr), 64'd0);
        check("t6_post_pc_ready", 64'(pc_ready), 64'd1);
        push_exp(32'd0);
        push_exp(32'd1);
        run_until_drained("t6", 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
